mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Parametrised M-stage memory-port arbiter for an N-lane superscalar pipeline; serialises same-cycle
//  loads/stores from multiple lanes onto the single data-memory port in program (lane-index) order.
//  Drives the hold on the E/M pipeline registers, the W-stage bubble and the memory lane select.
//  Also covers the single-access wait case (memory not ready), and adds a sticky watchdog on a hung port.
// PARAMETERS
//  LANES    2     number of issue lanes (>=2); lane 0 is oldest in program order
//  LW       1     lane-index width, = max(1,$clog2(LANES)); set by the instantiating module
//  TIMEOUT  255   consecutive not-ready cycles on one access before timeout_err sets; 0 disables
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      asynchronous, active-low; clears all state immediately
//  mem_rd       in   LANES  lane i in M is a load (MemtoRegM)
//  mem_wr       in   LANES  lane i in M is a store (MemWriteM); req[i] = mem_rd[i]|mem_wr[i]
//  mem_ready    in   1      memory completes the presented access this cycle
//  mem_en       out  1      port access valid this cycle
//  mem_we       out  1      presented access is a store (= mem_wr[mem_sel])
//  mem_sel      out  LW     lane whose address/data/dest drive the port
//  lane_ack     out  LANES  one-hot pulse: lane mem_sel's access completed (capture load data)
//  stall_em     out  1      hold E and M pipeline registers of all lanes
//  flush_w      out  1      insert bubble into W for all lanes (== stall_em)
//  busy         out  1      state != IDLE
//  timeout_err  out  1      sticky; watchdog expired
// BEHAVIOUR
//  Reset (async, low): state=IDLE, pending=0, wd_cnt=0, timeout_err=0; all outputs 0 while asserted.
//  States: IDLE, SERVE. pending[LANES-1:0] = lanes still to be serviced (registered).
//  Selection: mem_sel = lowest set index of src, src = req in IDLE, pending in SERVE.
//  mem_en = |src; mem_we = mem_wr[mem_sel] when mem_en, else 0; mem_sel=0 when !mem_en.
//  lane_ack[mem_sel] = mem_en & mem_ready (combinational, same cycle); other bits 0.
//  IDLE:
//   - req==0: all outputs 0, stay IDLE.
//   - exactly one req bit and mem_ready: zero-stall access, ack pulse, stall_em=0, stay IDLE.
//   - otherwise: stall_em=1; next pending = req with acked bit cleared; go SERVE.
//  SERVE (req inputs held constant by stall; arbiter uses pending only, ignores req changes):
//   - mem_ready: clear pending[mem_sel]; if that empties pending -> IDLE next cycle.
//   - stall_em = (popcount(pending)>1) | !mem_ready; drops in the cycle the last access completes,
//     so the pipeline advances on that edge with no extra bubble.
//  Latency: k requesting lanes, all ready immediately -> k-1 stall cycles; each not-ready cycle adds one.
//  Stores and loads are treated identically; no reordering; each lane acked exactly once per bundle.
//  flush_w = stall_em every cycle (held M results must not retire twice).
//  Watchdog: wd_cnt increments on mem_en & !mem_ready, clears on mem_ready or !mem_en;
//   when wd_cnt reaches TIMEOUT, timeout_err sets and holds until reset; arbitration unaffected.
//   wd_cnt saturates at TIMEOUT; width = $clog2(TIMEOUT+1).
//  Reset mid-SERVE: pending discarded, IDLE immediately; no ack emitted for unserviced lanes.
//  No combinational path from mem_ready to mem_sel/mem_we/mem_en; mem_ready reaches only lane_ack,
//   stall_em, flush_w.
// TESTING
//  1 LANES=2, mem_rd=01, mem_ready=1 -> lane_ack=01 same cycle, stall_em=0, busy stays 0.
//  2 LANES=2, mem_rd=01 mem_wr=10, mem_ready=1 -> cyc0 sel0 ack01 stall1; cyc1 sel1 we1 ack10 stall0; IDLE.
//  3 LANES=4, req=1011, mem_ready low 2 cycles per access -> acks in order 0,1,3; stall_em high 8 cycles,
//    low on the cycle of the 3rd ack.
//  4 Single load, mem_ready=0 for 3 cycles -> stall_em=1 for 3 cycles, ack on 4th, no SERVE bubble after.
//  5 TIMEOUT=4, req=01, mem_ready=0 for 6 cycles -> timeout_err rises after 4th not-ready cycle and stays
//    high after ready returns.
//  6 LANES=2, req=11, reset low one cycle after entering SERVE -> all outputs 0 immediately, pending=0;
//    after release with req=00 stays IDLE, no ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// M-stage memory-port arbiter: serialises same-cycle lane accesses onto one data port
// in lane-index order, stalls E/M and bubbles W while a bundle is draining.
module mem_port_arbiter #(
    parameter int LANES   = 2,
    parameter int LW      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] mem_rd,
    input  logic [LANES-1:0] mem_wr,
    input  logic             mem_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [LW-1:0]    mem_sel,
    output logic [LANES-1:0] lane_ack,
    output logic             stall_em,
    output logic             flush_w,
    output logic             busy,
    output logic             timeout_err
);

    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, SERVE} state_t;

    state_t           state;
    logic [LANES-1:0] pending;
    logic [LANES-1:0] req;
    logic [LANES-1:0] src;
    logic [LANES-1:0] sel_mask;
    logic             multi;
    logic [WDW-1:0]   wd_cnt;

    assign req = mem_rd | mem_wr;

    // Gating by reset keeps every output low while reset is held, even with req active.
    always_comb begin
        src = '0;
        if (reset) src = (state == SERVE) ? pending : req;
    end

    always_comb begin
        mem_sel  = '0;
        sel_mask = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (src[i]) begin
                mem_sel  = LW'(i);
                sel_mask = LANES'(1) << i;
            end
        end
    end

    assign multi    = |(src & (src - LANES'(1)));
    assign mem_en   = |src;
    assign mem_we   = |(mem_wr & sel_mask);
    assign lane_ack = mem_ready ? sel_mask : '0;
    assign stall_em = mem_en & (multi | ~mem_ready);
    assign flush_w  = stall_em;
    assign busy     = (state == SERVE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall_em) begin
                        state   <= SERVE;
                        pending <= req & ~lane_ack;
                    end
                end
                SERVE: begin
                    if (mem_ready) begin
                        pending <= pending & ~sel_mask;
                        if ((pending & ~sel_mask) == '0) state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Watchdog counts consecutive not-ready cycles of the presented access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (TIMEOUT != 0) begin
            if (mem_en && !mem_ready) begin
                if (wd_cnt != WDW'(TIMEOUT)) wd_cnt <= wd_cnt + WDW'(1);
                if (wd_cnt == WDW'(TIMEOUT - 1)) timeout_err <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table and corner sequences on a 2-lane instance,
// randomized bundles on a 4-lane instance checked against a per-bundle queue model.
module tb_mem_port_arbiter;

    localparam int TO2 = 4;
    localparam int TO4 = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rd2 = '0, wr2 = '0, ack2;
    logic       rdy2 = 1'b0, en2, we2, stall2, flush2, busy2, to2;
    logic [0:0] sel2;

    logic [3:0] rd4 = '0, wr4 = '0, ack4;
    logic       rdy4 = 1'b0, en4, we4, stall4, flush4, busy4, to4;
    logic [1:0] sel4;

    mem_port_arbiter #(.LANES(2), .LW(1), .TIMEOUT(TO2)) dut2 (
        .clk(clk), .reset(rst_n), .mem_rd(rd2), .mem_wr(wr2), .mem_ready(rdy2),
        .mem_en(en2), .mem_we(we2), .mem_sel(sel2), .lane_ack(ack2),
        .stall_em(stall2), .flush_w(flush2), .busy(busy2), .timeout_err(to2));

    mem_port_arbiter #(.LANES(4), .LW(2), .TIMEOUT(TO4)) dut4 (
        .clk(clk), .reset(rst_n), .mem_rd(rd4), .mem_wr(wr4), .mem_ready(rdy4),
        .mem_en(en4), .mem_we(we4), .mem_sel(sel4), .lane_ack(ack4),
        .stall_em(stall4), .flush_w(flush4), .busy(busy4), .timeout_err(to4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic en, input logic we, input logic sel,
                        input logic [1:0] ack, input logic stall, input logic busy, input logic to);
        chk({tag, ".en"},    32'(en2),    32'(en));
        chk({tag, ".we"},    32'(we2),    32'(we));
        chk({tag, ".sel"},   32'(sel2),   32'(sel));
        chk({tag, ".ack"},   32'(ack2),   32'(ack));
        chk({tag, ".stall"}, 32'(stall2), 32'(stall));
        chk({tag, ".flush"}, 32'(flush2), 32'(stall));
        chk({tag, ".busy"},  32'(busy2),  32'(busy));
        chk({tag, ".to"},    32'(to2),    32'(to));
    endtask

    task automatic chk4(input string tag, input logic en, input logic we, input logic [1:0] sel,
                        input logic [3:0] ack, input logic stall, input logic busy, input logic to);
        chk({tag, ".en"},    32'(en4),    32'(en));
        chk({tag, ".we"},    32'(we4),    32'(we));
        chk({tag, ".sel"},   32'(sel4),   32'(sel));
        chk({tag, ".ack"},   32'(ack4),   32'(ack));
        chk({tag, ".stall"}, 32'(stall4), 32'(stall));
        chk({tag, ".flush"}, 32'(flush4), 32'(stall));
        chk({tag, ".busy"},  32'(busy4),  32'(busy));
        chk({tag, ".to"},    32'(to4),    32'(to));
    endtask

    typedef struct {
        logic [1:0] rd, wr;
        logic       rdy;
        logic       en, we, sel;
        logic [1:0] ack;
        logic       stall, busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int q[$];
        int age, nr_run, stall_cnt;
        logic to_exp;
        logic [3:0] cur_rd, cur_wr;
        logic rdy;
        int lanes3[3];

        //            rd     wr     rdy   en    we    sel   ack    stall busy
        tbl[0]  = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        tbl[3]  = '{2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[7]  = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1};
        tbl[9]  = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        // Outputs must stay low while reset is held, even with a request present.
        rd2 = 2'b01; rdy2 = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk2("rst_hold", 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; rd2 = '0;

        foreach (tbl[i]) begin
            @(negedge clk);
            rd2 = tbl[i].rd; wr2 = tbl[i].wr; rdy2 = tbl[i].rdy;
            #1 chk2($sformatf("tbl%0d", i), tbl[i].en, tbl[i].we, tbl[i].sel,
                    tbl[i].ack, tbl[i].stall, tbl[i].busy, 1'b0);
        end

        // Four lanes, req=1011, two not-ready cycles before each access completes.
        lanes3 = '{0, 1, 3};
        stall_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rd4 = 4'b1001; wr4 = 4'b0010; rdy4 = (c % 3 == 2);
            #1;
            chk4($sformatf("four%0d", c), 1'b1, lanes3[c / 3] == 1, 2'(lanes3[c / 3]),
                 (c % 3 == 2) ? 4'(1 << lanes3[c / 3]) : 4'b0000, c != 8, c > 0, 1'b0);
            stall_cnt += int'(stall4);
        end
        chk("four.stall_cycles", 32'(stall_cnt), 32'd8);
        @(negedge clk);
        rd4 = '0; wr4 = '0; rdy4 = 1'b0;
        #1 chk4("four.after", 0, 0, 2'd0, 4'b0000, 0, 0, 0);

        // Single load waits three cycles; no extra bubble once it completes.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rd2 = (c < 4) ? 2'b01 : 2'b00; wr2 = '0; rdy2 = (c == 3);
            #1;
            if (c < 4)
                chk2($sformatf("wait%0d", c), 1, 0, 0, (c == 3) ? 2'b01 : 2'b00, c < 3, c > 0, 0);
            else
                chk2("wait.after", 0, 0, 0, 2'b00, 0, 0, 0);
        end

        // Watchdog on the 2-lane instance: sets after the 4th not-ready cycle, sticky.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rd2 = (c < 7) ? 2'b01 : 2'b00; rdy2 = (c == 6);
            #1 chk($sformatf("wd%0d.to", c), 32'(to2), 32'(c >= 4));
        end

        // Reset in the middle of a bundle.
        @(negedge clk);
        rd2 = 2'b11; rdy2 = 1'b0;
        @(negedge clk);
        #1 chk("mid.busy_before", 32'(busy2), 32'd1);
        rst_n = 1'b0;
        #1 chk2("mid.in_reset", 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; rd2 = 2'b00; rdy2 = 1'b1;
        #1 chk2("mid.release", 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        #1 chk2("mid.idle", 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        rd2 = 2'b01;
        #1 chk2("mid.fresh", 1, 0, 0, 2'b01, 0, 0, 0);
        @(negedge clk);
        rd2 = 2'b00;

        // Randomized bundles on the 4-lane instance against a service-order queue model.
        age = 0; nr_run = 0; to_exp = 1'b0; cur_rd = '0; cur_wr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic e_en, e_we, e_stall;
            logic [1:0] e_sel;
            logic [3:0] e_ack;
            @(negedge clk);
            if (q.size() == 0) begin
                cur_rd = 4'($urandom_range(0, 15));
                cur_wr = 4'($urandom_range(0, 15)) & ~cur_rd;
                if ($urandom_range(0, 5) == 0) begin cur_rd = '0; cur_wr = '0; end
                age = 0;
                for (int i = 0; i < 4; i++) if (cur_rd[i] | cur_wr[i]) q.push_back(i);
            end
            rdy = ($urandom_range(0, 9) < ((cyc < 1500) ? 7 : 3));
            rd4 = cur_rd; wr4 = cur_wr; rdy4 = rdy;
            #1;
            e_en    = (q.size() > 0);
            e_sel   = e_en ? 2'(q[0]) : 2'd0;
            e_we    = e_en ? cur_wr[e_sel] : 1'b0;
            e_ack   = (e_en && rdy) ? 4'(1 << q[0]) : 4'b0000;
            e_stall = e_en && (q.size() > 1 || !rdy);
            chk4($sformatf("rnd%0d", cyc), e_en, e_we, e_sel, e_ack, e_stall, age > 0, to_exp);
            if (e_en && !rdy) nr_run++; else nr_run = 0;
            if (nr_run >= TO4) to_exp = 1'b1;
            if (e_en && rdy) void'(q.pop_front());
            age++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
